// File: rtl/ahb_mtx_out_arbiter_param_if.sv
// Bus-side signals seen by one matrix output-stage arbiter.
// The master side drives the muxed address phase; the slave side is the arbiter.
interface ahb_mtx_out_arbiter_param_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 hold_active;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, hold_active
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, hold_active
  );
endinterface

// File: rtl/ahb_mtx_out_arbiter_param.sv
// Output-stage arbiter for one shared slave port of the AHB matrix.
// Grants one input stage at a time, holding across locked, fixed-length and short INCR bursts.
module ahb_mtx_out_arbiter_param #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 2,
  parameter int ARB_MODE         = 0,
  parameter int INCR_BEATS       = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input logic                        HCLK,
  input logic                        HRESETn,
  ahb_mtx_out_arbiter_param_if.slave bus
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [3:0]        remain_q, remain_nxt;
  logic              hold_q, hold_nxt;
  logic [1:0]        early_q, early_nxt;
  logic [PORT_W-1:0] grant_q, grant_nxt;
  logic              no_port_q, no_port_nxt;

  logic              low_hit, oth_hit, hi_hit, sw_hit;
  logic [PORT_W-1:0] low_idx, oth_idx, hi_idx, sw_idx;

  // Burst tracker: remain counts SEQ beats still owed after the current one.
  always_comb begin
    remain_nxt = remain_q;
    hold_nxt   = hold_q;
    if (!bus.HSELM) begin
      remain_nxt = '0;
      hold_nxt   = 1'b0;
    end else begin
      case (bus.HTRANSM)
        TR_IDLE: begin
          remain_nxt = '0;
          hold_nxt   = 1'b0;
        end
        TR_BUSY: ;
        TR_SEQ: begin
          if (remain_q == '0) hold_nxt = 1'b0;
          else                remain_nxt = remain_q - 4'd1;
        end
        TR_NONSEQ: begin
          case (bus.HBURSTM)
            3'b110, 3'b111: begin remain_nxt = 4'd14; hold_nxt = 1'b1; end
            3'b100, 3'b101: begin remain_nxt = 4'd6;  hold_nxt = 1'b1; end
            3'b010, 3'b011: begin remain_nxt = 4'd2;  hold_nxt = 1'b1; end
            3'b001: begin
              if (early_q == 2'(EARLY_INCR_LIMIT)) begin
                remain_nxt = '0;
                hold_nxt   = 1'b0;
              end else begin
                remain_nxt = 4'(INCR_BEATS - 2);
                hold_nxt   = 1'b1;
              end
            end
            default: begin remain_nxt = '0; hold_nxt = 1'b0; end
          endcase
        end
        default: begin remain_nxt = 'x; hold_nxt = 1'bx; end
      endcase
    end
  end

  // Counts INCR bursts restarted before their hold ran out; starves nobody past the limit.
  always_comb begin
    early_nxt = early_q;
    if (!hold_nxt)                                      early_nxt = '0;
    else if (hold_q && bus.HTRANSM == TR_NONSEQ && early_q != 2'd3) early_nxt = early_q + 2'd1;
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    low_hit = 1'b0; low_idx = '0;
    oth_hit = 1'b0; oth_idx = '0;
    hi_hit  = 1'b0; hi_idx  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_port[i]) begin
        low_hit = 1'b1;
        low_idx = PORT_W'(i);
        if (PORT_W'(i) != grant_q) begin oth_hit = 1'b1; oth_idx = PORT_W'(i); end
        if (PORT_W'(i) >  grant_q) begin hi_hit  = 1'b1; hi_idx  = PORT_W'(i); end
      end
    end
  end

  // With nothing above the current port, the lowest other requester is the wrapped choice.
  assign sw_hit = oth_hit;
  assign sw_idx = (ARB_MODE == 0 && hi_hit) ? hi_idx : oth_idx;

  always_comb begin
    grant_nxt   = grant_q;
    no_port_nxt = no_port_q;
    if (bus.HMASTLOCKM || hold_nxt) begin
      grant_nxt   = grant_q;
    end else if (no_port_q) begin
      if (low_hit) begin
        grant_nxt   = low_idx;
        no_port_nxt = 1'b0;
      end
    end else if (sw_hit) begin
      grant_nxt   = sw_idx;
      no_port_nxt = 1'b0;
    end else if (!bus.HSELM) begin
      no_port_nxt = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain_q  <= '0;
      hold_q    <= 1'b0;
      early_q   <= '0;
      grant_q   <= '0;
      no_port_q <= 1'b1;
    end else if (bus.HREADYM) begin
      remain_q  <= remain_nxt;
      hold_q    <= hold_nxt;
      early_q   <= early_nxt;
      grant_q   <= grant_nxt;
      no_port_q <= no_port_nxt;
    end
  end

  assign bus.addr_in_port = grant_q;
  assign bus.no_port      = no_port_q;
  assign bus.hold_active  = hold_q;
endmodule

// File: tb/tb_ahb_mtx_out_arbiter_param.sv
// Drives a round-robin and a fixed-priority arbiter with the same bus traffic
// and compares {addr_in_port, no_port, hold_active} against queued expectations.
module tb_ahb_mtx_out_arbiter_param;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SNGL = 3'b000, INCR = 3'b001, INC8 = 3'b101, INC16 = 3'b111;

  logic HCLK, HRESETn;
  int   n_chk, n_fail;

  ahb_mtx_out_arbiter_param_if #(.NUM_PORTS(4), .PORT_W(2)) bus_rr ();
  ahb_mtx_out_arbiter_param_if #(.NUM_PORTS(4), .PORT_W(2)) bus_fp ();

  assign bus_fp.req_port   = bus_rr.req_port;
  assign bus_fp.HREADYM    = bus_rr.HREADYM;
  assign bus_fp.HSELM      = bus_rr.HSELM;
  assign bus_fp.HTRANSM    = bus_rr.HTRANSM;
  assign bus_fp.HBURSTM    = bus_rr.HBURSTM;
  assign bus_fp.HMASTLOCKM = bus_rr.HMASTLOCKM;

  ahb_mtx_out_arbiter_param #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(0),
    .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)) u_rr (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_rr.slave));
  ahb_mtx_out_arbiter_param #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(1),
    .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)) u_fp (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_fp.slave));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string      tag;
    logic [3:0] rr;
    logic [3:0] fp;
  } exp_t;
  exp_t sb[$];

  function automatic logic [3:0] E(input int p, input int n, input int h);
    logic [31:0] pv, nv, hv;
    pv = p; nv = n; hv = h;
    return {pv[1:0], nv[0], hv[0]};
  endfunction

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got port=%0d no_port=%0b hold=%0b, want port=%0d no_port=%0b hold=%0b",
               tag, act[3:2], act[1], act[0], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [3:0] obs_rr();
    return {bus_rr.addr_in_port, bus_rr.no_port, bus_rr.hold_active};
  endfunction
  function automatic logic [3:0] obs_fp();
    return {bus_fp.addr_in_port, bus_fp.no_port, bus_fp.hold_active};
  endfunction

  // Drive one address-phase cycle, queue its expected outcome, compare after the edge.
  task automatic step(input string tag, input logic [3:0] req, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                      input logic rdy, input logic [3:0] e_rr, input logic [3:0] e_fp);
    exp_t e;
    bus_rr.req_port   = req;
    bus_rr.HSELM      = sel;
    bus_rr.HTRANSM    = tr;
    bus_rr.HBURSTM    = bu;
    bus_rr.HMASTLOCKM = lk;
    bus_rr.HREADYM    = rdy;
    sb.push_back('{tag, e_rr, e_fp});
    @(posedge HCLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".rr"}, obs_rr(), e.rr);
    chk({e.tag, ".fp"}, obs_fp(), e.fp);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    HRESETn = 1'b0;
    bus_rr.req_port = 4'b0000; bus_rr.HSELM = 1'b0; bus_rr.HTRANSM = IDLE;
    bus_rr.HBURSTM = SNGL; bus_rr.HMASTLOCKM = 1'b0; bus_rr.HREADYM = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset.rr", obs_rr(), E(0, 1, 0));
    chk("reset.fp", obs_fp(), E(0, 1, 0));
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Arbitration from idle, round-robin upward and wrap, fixed-priority lowest-other
    step("first",   4'b1010, 1'b0, IDLE, SNGL, 1'b0, 1'b1, E(1,0,0), E(1,0,0));
    step("rr_up",   4'b1011, 1'b1, NSEQ, SNGL, 1'b0, 1'b1, E(3,0,0), E(0,0,0));
    step("rr_wrap", 4'b0011, 1'b1, NSEQ, SNGL, 1'b0, 1'b1, E(0,0,0), E(1,0,0));
    step("to2",     4'b0100, 1'b1, IDLE, SNGL, 1'b0, 1'b1, E(2,0,0), E(2,0,0));
    step("stall",   4'b1000, 1'b1, IDLE, SNGL, 1'b0, 1'b0, E(2,0,0), E(2,0,0));

    // INCR8 with one BUSY: grant held for the NONSEQ, 7 SEQs and the BUSY
    step("i8_ns",   4'b1111, 1'b1, NSEQ, INC8, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    for (int k = 0; k < 3; k++)
      step("i8_seqa", 4'b1111, 1'b1, SEQ, INC8, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    step("i8_busy", 4'b1111, 1'b1, BUSY, INC8, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    for (int k = 0; k < 3; k++)
      step("i8_seqb", 4'b1111, 1'b1, SEQ, INC8, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    step("i8_end",  4'b1111, 1'b1, SEQ, INC8, 1'b0, 1'b1, E(3,0,0), E(0,0,0));

    // Locked transfer beats all requests
    step("to1",     4'b0010, 1'b1, IDLE, SNGL, 1'b0, 1'b1, E(1,0,0), E(1,0,0));
    for (int k = 0; k < 5; k++)
      step("lock",  4'b1111, 1'b1, IDLE, SNGL, 1'b1, 1'b1, E(1,0,0), E(1,0,0));
    step("unlock",  4'b1111, 1'b1, IDLE, SNGL, 1'b0, 1'b1, E(2,0,0), E(0,0,0));

    // Back-to-back short INCR bursts: restart beyond the limit stops holding
    step("to0",     4'b0001, 1'b1, IDLE, SNGL, 1'b0, 1'b1, E(0,0,0), E(0,0,0));
    step("inc1_ns", 4'b1001, 1'b1, NSEQ, INCR, 1'b0, 1'b1, E(0,0,1), E(0,0,1));
    step("inc1_sq", 4'b1001, 1'b1, SEQ,  INCR, 1'b0, 1'b1, E(0,0,1), E(0,0,1));
    step("inc2_ns", 4'b1001, 1'b1, NSEQ, INCR, 1'b0, 1'b1, E(0,0,1), E(0,0,1));
    step("inc2_sq", 4'b1001, 1'b1, SEQ,  INCR, 1'b0, 1'b1, E(0,0,1), E(0,0,1));
    step("inc3_ns", 4'b1001, 1'b1, NSEQ, INCR, 1'b0, 1'b1, E(3,0,0), E(3,0,0));

    // Nobody requesting and slave deselected: release, keeping the last index
    step("drop",    4'b0000, 1'b0, IDLE, SNGL, 1'b0, 1'b1, E(3,1,0), E(3,1,0));
    step("nop_pick",4'b0100, 1'b0, IDLE, SNGL, 1'b0, 1'b1, E(2,0,0), E(2,0,0));

    // Reset in the middle of an INCR16 returns everything at once
    step("i16_ns",  4'b1111, 1'b1, NSEQ, INC16, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    step("i16_sq",  4'b1111, 1'b1, SEQ,  INC16, 1'b0, 1'b1, E(2,0,1), E(2,0,1));
    #3 HRESETn = 1'b0;
    #1;
    chk("midrst.rr", obs_rr(), E(0,1,0));
    chk("midrst.fp", obs_fp(), E(0,1,0));
    bus_rr.req_port = 4'b0000; bus_rr.HSELM = 1'b0; bus_rr.HTRANSM = IDLE;
    @(negedge HCLK) HRESETn = 1'b1;
    step("post_rst",4'b0000, 1'b0, IDLE, SNGL, 1'b0, 1'b1, E(0,1,0), E(0,1,0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
